mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Shares the single DA_VINCI memory port between two requesters: the instruction-fetch unit (IF, read-only) and the data load/store unit (DM, read/write).
- Sits between the processor and the memory instance. Sequences READ/WRITE strobes for a memory with a fixed access time.
- Applies data-first priority with a starvation guard for instruction fetch.
- Returns read data and a one-cycle ACK to the winning requester.

Parameters:
ADDR_W, 26, memory word-address width (64M words)
DATA_W, 32, data word width
MEM_LATENCY, 1, cycles MEM_READ/MEM_WRITE are held per access (legal range 1..15)
STARVE_LIMIT, 4, consecutive DM grants with IF pending before IF is forced to win (legal range 1..15)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
IF_REQ  in  1  instruction-fetch read request
IF_ADDR  in  ADDR_W  fetch address
IF_RDATA  out  DATA_W  fetched word, valid while IF_ACK=1
IF_ACK  out  1  one-cycle completion pulse for IF
DM_REQ  in  1  data access request
DM_WE  in  1  1=write, 0=read
DM_ADDR  in  ADDR_W  data address
DM_WDATA  in  DATA_W  write data
DM_RDATA  out  DATA_W  read word, valid while DM_ACK=1
DM_ACK  out  1  one-cycle completion pulse for DM
MEM_ADDR  out  ADDR_W  memory address
MEM_READ  out  1  memory read strobe
MEM_WRITE  out  1  memory write strobe
MEM_DATA_IN  out  DATA_W  write data driven into memory
MEM_DATA_OUT  in  DATA_W  read data returned by memory
BUSY  out  1  high in any state other than IDLE

Behaviour:
- **Reset.** RST low, asynchronous, takes effect mid-access. All outputs go to 0, state returns to IDLE, the latency counter and starvation counter clear, and any in-flight access is dropped with no ACK. Memory contents are not guaranteed for an aborted write.
- **States:** IDLE, ACCESS, DONE.
- **IDLE**
  - MEM_* = 0.
  - If no REQ is high, stay in IDLE.
  - Otherwise, on the next edge, register the winner, address, WE and write data (DM only), and go to ACCESS.
  - Requester signals changing after this edge are ignored.
- **Arbitration (in IDLE)**
  - Only one REQ high: that port wins.
  - Both high: DM wins, unless the starvation counter equals STARVE_LIMIT, in which case IF wins.
- **Starvation counter**
  - Increments on each DM grant while IF_REQ=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant, and on any DM grant while IF_REQ=0.
- **ACCESS**
  - Drives MEM_ADDR from the latched address for exactly MEM_LATENCY cycles.
  - Read: MEM_READ=1. Write: MEM_WRITE=1 and MEM_DATA_IN = latched write data.
  - MEM_READ and MEM_WRITE are never high together.
  - On the last ACCESS cycle, MEM_DATA_OUT is registered into the winner's RDATA register (reads only). Then go to DONE.
- **DONE**
  - Strobes return to 0; the winner's ACK=1 for this one cycle. Write ACK means the write has completed.
  - RDATA holds its value until the next read completes on that port.
  - Always returns to IDLE.
- **Timing**
  - A request first seen in IDLE at cycle n gets ACK at cycle n+1+MEM_LATENCY.
  - Minimum spacing between grants is MEM_LATENCY+2 cycles.
- **Requester protocol**
  - Hold REQ until ACK is seen, and deassert on the edge after ACK.
  - REQ still high in the following IDLE cycle is treated as a new request.
  - Dropping REQ before grant withdraws the request. Dropping it after grant has no effect.
- **Simultaneous events**
  - A REQ rising during ACCESS or DONE waits for IDLE.
  - Both ACKs are never high in the same cycle.
- **Widths:** addresses and data pass through unmodified; there is no arithmetic beyond the 4-bit counters.

Decomposition:
- **Shared package / prj_definition:**
  - ADDR_W=26 and DATA_W=32, aligned with ADDRESS_INDEX_LIMIT and DATA_INDEX_LIMIT.
  - State encodings IDLE=2'b00, ACCESS=2'b01, DONE=2'b10.
  - Port-ID constants PORT_IF=1'b0, PORT_DM=1'b1.
- **One sub-module, mem_arb_select:** combinational winner selection plus the starvation counter register (CLK, RST, IF_REQ, DM_REQ, grant_en → winner).
- The FSM, latency counter and data latches stay in mem_access_arbiter.

Test Plan:
- **IF read alone** (MEM_LATENCY=1): memory word 0x0100_0000 preloaded with 0x0000_0005; IF_REQ=1 with IF_ADDR=0x0100_0000 at cycle 0 → MEM_READ=1 at cycle 1, IF_ACK=1 at cycle 2, IF_RDATA=0x0000_0005, DM_ACK never high.
- **DM write then read:** write 0xDEADBEEF to 0x03FF_FFF0 → MEM_WRITE for 1 cycle, MEM_DATA_IN=0xDEADBEEF, DM_ACK 2 cycles after the request; a following DM read of the same address → DM_RDATA=0xDEADBEEF.
- **Collision:** IF_REQ and DM_REQ rise together → DM granted first, IF granted next at the following IDLE (ACKs 3 cycles apart); no cycle with both strobes or both ACKs high.
- **Starvation guard** (STARVE_LIMIT=4): DM_REQ re-asserted continuously with IF_REQ held high → 4 DM grants, then IF wins the 5th grant, and the counter returns to 0.
- **Latency sweep:** MEM_LATENCY=3 → MEM_READ high for exactly 3 cycles and ACK at request+4; the data sampled is the value on the 3rd strobe cycle.
- **Reset mid-access:** RST low during the 2nd ACCESS cycle of a DM write → MEM_WRITE, BUSY and ACKs drop to 0 immediately; after RST rises, no ACK is produced until a fresh request is made.

Source files
------------

// File: rtl/mem_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter_pkg
// Shared definitions for the DA_VINCI memory-port arbiter:
//   - default address/data widths, tied to the processor's index limits
//   - arbiter FSM state encoding
//   - requester port identifiers used to tag the granted access
// -----------------------------------------------------------------------------
package mem_access_arbiter_pkg;

   // Highest bit index of a memory word address and of a data word.
   localparam int ADDRESS_INDEX_LIMIT = 25;
   localparam int DATA_INDEX_LIMIT    = 31;

   localparam int DEF_ADDR_W = ADDRESS_INDEX_LIMIT + 1;
   localparam int DEF_DATA_W = DATA_INDEX_LIMIT + 1;

   // Width of the latency and starvation counters (limits are 1..15).
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } arb_state_t;

   typedef logic port_id_t;

   localparam port_id_t PORT_IF = 1'b0;
   localparam port_id_t PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// -----------------------------------------------------------------------------
// mem_arb_select
// Winner selection between the instruction-fetch (IF) and data (DM) requesters,
// plus the starvation counter that eventually forces an IF grant when DM keeps
// winning while IF is waiting.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-low reset
//   IF_REQ   in   instruction-fetch request
//   DM_REQ   in   data access request
//   grant_en in   a grant is being issued this cycle (arbiter idle, a REQ high)
//   winner   out  port that wins if a grant is issued this cycle
// -----------------------------------------------------------------------------
module mem_arb_select
   import mem_access_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)(
   input  logic     CLK,
   input  logic     RST,
   input  logic     IF_REQ,
   input  logic     DM_REQ,
   input  logic     grant_en,
   output port_id_t winner
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             if_forced;

   // Data-first priority; IF only overrides a competing DM request once it
   // has been passed over STARVE_LIMIT times in a row.
   always_comb begin
      if_forced = IF_REQ && (starve_cnt == LIMIT);
      if (DM_REQ && !if_forced) begin
         winner = PORT_DM;
      end else begin
         winner = PORT_IF;
      end
   end

   // Count DM grants that left IF waiting, saturating at the limit. Any IF
   // grant, or a DM grant with nobody waiting, means IF is no longer starved.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         starve_cnt <= '0;
      end else if (grant_en) begin
         if ((winner == PORT_DM) && IF_REQ) begin
            if (starve_cnt != LIMIT) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
// Shares the single DA_VINCI memory port between the instruction-fetch unit
// (read-only) and the data load/store unit (read/write). A granted access is
// latched, the memory strobe is held for MEM_LATENCY cycles, and a one-cycle
// ACK is returned to the winner.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-low reset
//   IF_REQ, IF_ADDR          fetch request and address
//   IF_RDATA, IF_ACK         fetched word (valid with ACK), completion pulse
//   DM_REQ, DM_WE            data request, 1=write 0=read
//   DM_ADDR, DM_WDATA        data address and write data
//   DM_RDATA, DM_ACK         read word (valid with ACK), completion pulse
//   MEM_ADDR                 memory address
//   MEM_READ, MEM_WRITE      memory strobes (never both high)
//   MEM_DATA_IN              write data into memory
//   MEM_DATA_OUT             read data from memory
//   BUSY                     high whenever an access is in flight
// -----------------------------------------------------------------------------
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   output logic [DATA_W-1:0] IF_RDATA,
   output logic              IF_ACK,
   input  logic              DM_REQ,
   input  logic              DM_WE,
   input  logic [ADDR_W-1:0] DM_ADDR,
   input  logic [DATA_W-1:0] DM_WDATA,
   output logic [DATA_W-1:0] DM_RDATA,
   output logic              DM_ACK,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [DATA_W-1:0] MEM_DATA_IN,
   input  logic [DATA_W-1:0] MEM_DATA_OUT,
   output logic              BUSY
);

   // Counter value on the final strobe cycle of an access.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

   arb_state_t        state_q;
   arb_state_t        state_d;
   port_id_t          winner;
   port_id_t          owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic [CNT_W-1:0]  lat_cnt_q;
   logic              any_req;
   logic              grant_en;
   logic              last_beat;

   assign any_req   = IF_REQ | DM_REQ;
   assign grant_en  = (state_q == IDLE) && any_req;
   assign last_beat = (state_q == ACCESS) && (lat_cnt_q == LAST_CNT);

   mem_arb_select #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_select (
      .CLK      (CLK),
      .RST      (RST),
      .IF_REQ   (IF_REQ),
      .DM_REQ   (DM_REQ),
      .grant_en (grant_en),
      .winner   (winner)
   );

   // FSM state register; reset drops any in-flight access immediately.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: one grant per IDLE visit, so back-to-back grants are always
   // separated by the full ACCESS + DONE sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req)   state_d = ACCESS;
         ACCESS:  if (last_beat) state_d = DONE;
         DONE:                   state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Capture the winning request at grant time; requester inputs are ignored
   // from here until the arbiter is idle again. IF accesses are always reads.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         owner_q <= PORT_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant_en) begin
         owner_q <= winner;
         if (winner == PORT_DM) begin
            we_q    <= DM_WE;
            addr_q  <= DM_ADDR;
            wdata_q <= DM_WDATA;
         end else begin
            we_q    <= 1'b0;
            addr_q  <= IF_ADDR;
            wdata_q <= '0;
         end
      end
   end

   // Latency counter: runs through the ACCESS cycles and rests at zero so the
   // next access always starts counting from the beginning.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lat_cnt_q <= '0;
      end else if ((state_q == ACCESS) && !last_beat) begin
         lat_cnt_q <= lat_cnt_q + 1'b1;
      end else begin
         lat_cnt_q <= '0;
      end
   end

   // Read data is sampled on the final strobe cycle into the owner's register
   // and then held until that port completes another read.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else if (last_beat && !we_q) begin
         if (owner_q == PORT_DM) begin
            dm_rdata_q <= MEM_DATA_OUT;
         end else begin
            if_rdata_q <= MEM_DATA_OUT;
         end
      end
   end

   // Outputs depend only on the current state and latched request, so they
   // fall to zero the moment reset forces the FSM back to IDLE.
   always_comb begin
      MEM_ADDR    = '0;
      MEM_READ    = 1'b0;
      MEM_WRITE   = 1'b0;
      MEM_DATA_IN = '0;
      IF_ACK      = 1'b0;
      DM_ACK      = 1'b0;
      BUSY        = (state_q != IDLE);
      case (state_q)
         ACCESS: begin
            MEM_ADDR  = addr_q;
            MEM_READ  = !we_q;
            MEM_WRITE = we_q;
            if (we_q) begin
               MEM_DATA_IN = wdata_q;
            end
         end
         DONE: begin
            IF_ACK = (owner_q == PORT_IF);
            DM_ACK = (owner_q == PORT_DM);
         end
         default: begin
         end
      endcase
   end

   assign IF_RDATA = if_rdata_q;
   assign DM_RDATA = dm_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_access_arbiter
// Self-checking bench for mem_access_arbiter. A main instance (latency 1,
// starvation limit 4) is attached to a small behavioural memory; a second
// instance (latency 3) has its read data driven directly so the sampling
// cycle can be observed.
// -----------------------------------------------------------------------------
module tb_mem_access_arbiter;

   localparam int AW     = 26;
   localparam int DW     = 32;
   localparam int LAT    = 1;
   localparam int STARVE = 4;
   localparam int LAT3   = 3;

   typedef struct {
      logic          port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      int            exp_ack;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, dm_req, dm_we;
   logic [AW-1:0] if_addr, dm_addr, mem_addr;
   logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_data_in, mem_dout;
   logic          if_ack, dm_ack, mem_read, mem_write, busy;

   logic          rst3_n;
   logic          if_req3, dm_req3, dm_we3;
   logic [AW-1:0] if_addr3, dm_addr3, mem_addr3;
   logic [DW-1:0] dm_wdata3, if_rdata3, dm_rdata3, mem_data_in3, m3_dout;
   logic          if_ack3, dm_ack3, mem_read3, mem_write3, busy3;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   vec_t          vecs [7];

   always #5 clk = ~clk;

   mem_access_arbiter #(
      .ADDR_W (AW), .DATA_W (DW), .MEM_LATENCY (LAT), .STARVE_LIMIT (STARVE)
   ) dut (
      .CLK (clk), .RST (rst_n),
      .IF_REQ (if_req), .IF_ADDR (if_addr), .IF_RDATA (if_rdata), .IF_ACK (if_ack),
      .DM_REQ (dm_req), .DM_WE (dm_we), .DM_ADDR (dm_addr), .DM_WDATA (dm_wdata),
      .DM_RDATA (dm_rdata), .DM_ACK (dm_ack),
      .MEM_ADDR (mem_addr), .MEM_READ (mem_read), .MEM_WRITE (mem_write),
      .MEM_DATA_IN (mem_data_in), .MEM_DATA_OUT (mem_dout), .BUSY (busy)
   );

   mem_access_arbiter #(
      .ADDR_W (AW), .DATA_W (DW), .MEM_LATENCY (LAT3), .STARVE_LIMIT (STARVE)
   ) dut3 (
      .CLK (clk), .RST (rst3_n),
      .IF_REQ (if_req3), .IF_ADDR (if_addr3), .IF_RDATA (if_rdata3), .IF_ACK (if_ack3),
      .DM_REQ (dm_req3), .DM_WE (dm_we3), .DM_ADDR (dm_addr3), .DM_WDATA (dm_wdata3),
      .DM_RDATA (dm_rdata3), .DM_ACK (dm_ack3),
      .MEM_ADDR (mem_addr3), .MEM_READ (mem_read3), .MEM_WRITE (mem_write3),
      .MEM_DATA_IN (mem_data_in3), .MEM_DATA_OUT (m3_dout), .BUSY (busy3)
   );

   // Behavioural memory for the main instance: writes land and read data is
   // presented on the falling edge, ready for the arbiter's next rising edge.
   initial begin
      mem[26'h100_0000] = 32'h0000_0005;
      mem_dout = '0;
      forever begin
         @(negedge clk);
         if (mem_write) mem[mem_addr] = mem_data_in;
         mem_dout = mem.exists(mem_addr) ? mem[mem_addr] : '0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One isolated transaction on the main instance, starting with it idle.
   task automatic applyStimulus(input vec_t v);
      int   ack_cyc;
      logic other_ack;
      ack_cyc   = -1;
      other_ack = 1'b0;
      if (v.port) begin
         dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            checkOutput("vec_mem_read", mem_read, !v.we);
            checkOutput("vec_mem_write", mem_write, v.we);
            checkOutput("vec_mem_addr", mem_addr, v.addr);
            if (v.we) checkOutput("vec_mem_data_in", mem_data_in, v.wdata);
         end
         if (v.port ? if_ack : dm_ack) other_ack = 1'b1;
         if (v.port ? dm_ack : if_ack) begin
            ack_cyc = c;
            if_req  = 1'b0;
            dm_req  = 1'b0;
         end
      end
      checkOutput("vec_ack_cycle", ack_cyc, v.exp_ack);
      checkOutput("vec_wrong_port_ack", other_ack, 1'b0);
      if (!v.we) checkOutput("vec_rdata", v.port ? dm_rdata : if_rdata, v.exp_rdata);
      if_req = 1'b0;
      dm_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("vec_idle_after", busy, 1'b0);
   endtask

   int            if_ack_c, dm_ack_c, n_acks, rd_cnt, rd_first, ack3;
   logic          both_high, act_seen;
   logic          order [6];
   logic          starve_exp [6];
   // reference model state for the randomized phase
   int            free_at, ack_at, grant_c, starve;
   logic          g_port, g_we, in_acc;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_rdata_exp;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 26'h100_0000, 32'h0,         32'h0000_0005, 2};
      vecs[1] = '{1'b1, 1'b1, 26'h3FF_FFF0, 32'hDEADBEEF,  32'h0,         2};
      vecs[2] = '{1'b1, 1'b0, 26'h3FF_FFF0, 32'h0,         32'hDEADBEEF,  2};
      vecs[3] = '{1'b0, 1'b0, 26'h3FF_FFF0, 32'h0,         32'hDEADBEEF,  2};
      vecs[4] = '{1'b1, 1'b1, 26'h000_0000, 32'hFFFF_FFFF, 32'h0,         2};
      vecs[5] = '{1'b1, 1'b0, 26'h000_0000, 32'h0,         32'hFFFF_FFFF, 2};
      vecs[6] = '{1'b0, 1'b0, 26'h3FF_FFFF, 32'h0,         32'h0,         2};
      starve_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; rst3_n = 1'b0;
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      if_req3 = 1'b0; dm_req3 = 1'b0; dm_we3 = 1'b0;
      if_addr3 = '0; dm_addr3 = '0; dm_wdata3 = '0; m3_dout = '0;
      #1;
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_if_ack", if_ack, 1'b0);
      checkOutput("reset_dm_ack", dm_ack, 1'b0);
      checkOutput("reset_strobes", {mem_read, mem_write}, 2'b00);
      checkOutput("reset_mem_addr", mem_addr, '0);
      checkOutput("reset_mem_data_in", mem_data_in, '0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1; rst3_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed transaction table");
      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      $display("[TB] collision sequence");
      if_req = 1'b1; if_addr = 26'h100_0000;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 26'h3FF_FFF0;
      if_ack_c = -1; dm_ack_c = -1; both_high = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         if ((mem_read && mem_write) || (if_ack && dm_ack)) both_high = 1'b1;
         if (dm_ack && dm_ack_c < 0) begin dm_ack_c = c; dm_req = 1'b0; end
         if (if_ack && if_ack_c < 0) begin if_ack_c = c; if_req = 1'b0; end
      end
      checkOutput("collision_dm_ack_cycle", dm_ack_c, 2);
      checkOutput("collision_if_ack_cycle", if_ack_c, 5);
      checkOutput("collision_overlap", both_high, 1'b0);
      checkOutput("collision_if_rdata", if_rdata, 32'h0000_0005);
      checkOutput("collision_dm_rdata", dm_rdata, 32'hDEADBEEF);

      $display("[TB] starvation guard sequence");
      if_req = 1'b1; if_addr = 26'h100_0000;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 26'h000_0000;
      n_acks = 0;
      for (int c = 1; c <= 40 && n_acks < 6; c++) begin
         @(posedge clk); #1;
         if (if_ack) begin order[n_acks] = 1'b0; n_acks++; end
         else if (dm_ack) begin order[n_acks] = 1'b1; n_acks++; end
      end
      if_req = 1'b0; dm_req = 1'b0;
      checkOutput("starve_grant_count", n_acks, 6);
      for (int i = 0; i < 6; i++) checkOutput("starve_grant_order", order[i], starve_exp[i]);
      @(posedge clk); #1;
      @(posedge clk); #1;

      $display("[TB] latency 3 sweep");
      if_req3 = 1'b1; if_addr3 = 26'h123_4567;
      rd_cnt = 0; rd_first = -1; ack3 = -1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         m3_dout = 32'hC0DE_0000 | c;
         if (mem_read3) begin
            rd_cnt++;
            if (rd_first < 0) rd_first = c;
         end
         if (if_ack3 && ack3 < 0) begin ack3 = c; if_req3 = 1'b0; end
      end
      checkOutput("lat3_strobe_cycles", rd_cnt, 3);
      checkOutput("lat3_first_strobe", rd_first, 1);
      checkOutput("lat3_ack_cycle", ack3, 4);
      checkOutput("lat3_sampled_data", if_rdata3, 32'hC0DE_0003);

      $display("[TB] reset during access");
      dm_req3 = 1'b1; dm_we3 = 1'b1; dm_addr3 = 26'h3FF_FFF0; dm_wdata3 = 32'hDEADBEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst_write_in_flight", mem_write3, 1'b1);
      #2 rst3_n = 1'b0;
      #1;
      checkOutput("rst_mem_write", mem_write3, 1'b0);
      checkOutput("rst_busy", busy3, 1'b0);
      checkOutput("rst_acks", {if_ack3, dm_ack3}, 2'b00);
      dm_req3 = 1'b0;
      @(posedge clk); #1;
      rst3_n = 1'b1;
      act_seen = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (if_ack3 || dm_ack3 || busy3) act_seen = 1'b1;
      end
      checkOutput("rst_no_stale_ack", act_seen, 1'b0);
      dm_req3 = 1'b1; dm_we3 = 1'b0;
      ack3 = -1;
      for (int c = 1; c <= 10 && ack3 < 0; c++) begin
         @(posedge clk); #1;
         if (dm_ack3) begin ack3 = c; dm_req3 = 1'b0; end
      end
      checkOutput("rst_fresh_request_ack", ack3, 4);

      // Randomized traffic against a transaction-level model: the arbiter is
      // free from free_at onward, a grant at cycle c strobes c+1..c+LAT and
      // acknowledges at c+LAT+1.
      $display("[TB] randomized traffic");
      rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      free_at = 0; ack_at = -1; grant_c = -100; starve = 0;
      g_port = 1'b0; g_we = 1'b0; g_addr = '0; g_rdata_exp = '0;
      for (int c = 0; c < 600; c++) begin
         in_acc = (c > grant_c) && (c <= grant_c + LAT);
         checkOutput("rnd_if_ack", if_ack, (c == ack_at) && !g_port);
         checkOutput("rnd_dm_ack", dm_ack, (c == ack_at) && g_port);
         checkOutput("rnd_busy", busy, (c > grant_c) && (c < free_at));
         checkOutput("rnd_mem_read", mem_read, in_acc && !g_we);
         checkOutput("rnd_mem_write", mem_write, in_acc && g_we);
         if (in_acc) checkOutput("rnd_mem_addr", mem_addr, g_addr);
         if (c == ack_at && !g_we)
            checkOutput("rnd_rdata", g_port ? dm_rdata : if_rdata, g_rdata_exp);

         if (c == ack_at) begin
            if (g_port) dm_req = 1'b0;
            else        if_req = 1'b0;
         end
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = 26'h1000 + 26'($urandom_range(0, 7));
         end
         if (!dm_req && $urandom_range(0, 2) == 0) begin
            dm_req   = 1'b1;
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = 26'h1000 + 26'($urandom_range(0, 7));
            dm_wdata = $urandom;
         end

         if (c >= free_at && (if_req || dm_req)) begin
            g_port = dm_req && !(if_req && starve == STARVE);
            if (g_port && if_req) starve = (starve < STARVE) ? starve + 1 : STARVE;
            else                  starve = 0;
            grant_c = c;
            ack_at  = c + LAT + 1;
            free_at = c + LAT + 2;
            g_we    = g_port ? dm_we : 1'b0;
            g_addr  = g_port ? dm_addr : if_addr;
            if (g_we) ref_mem[g_addr] = dm_wdata;
            else      g_rdata_exp = ref_mem.exists(g_addr) ? ref_mem[g_addr] : '0;
         end
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
